dcd_inst_queue: RTL and testbench

- Decoded-instruction queue directly downstream of the decode/interpret stage.
- Buffers 66-bit decoded instruction words and their backward-loop flag, and presents them to the allocation/rename stage.
- Provides first-word-fall-through (FWFT) dequeue, an almost-full stall back to fetch/decode, and a single-cycle flush for mispredict/recovery.

---
 rtl/dcd_inst_queue.sv | 112 +++++++++++
 tb/tb_dcd_inst_queue.sv | 131 +++++++++++++
 2 files changed

// File: rtl/dcd_inst_queue.sv
// Decoded-instruction FWFT queue between decode and allocate/rename, with almost-full stall and flush.
// Optional macro DIQ_BCK_LP_CNT_EN adds lp_cnt_out, a count of queued backward-loop entries.
module dcd_inst_queue #(
  parameter int DEPTH        = 8,
  parameter int AW           = 3,
  parameter int AFULL_MARGIN = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush_in,
  input  logic          wr_en_in,
  input  logic [65:0]   dcd_inst_in,
  input  logic          bck_lp_in,
  input  logic          rd_en_in,
  output logic [65:0]   dcd_inst_out,
  output logic          bck_lp_out,
  output logic          empty_out,
  output logic          full_out,
  output logic          afull_out,
  output logic [AW:0]   cnt_out
`ifdef DIQ_BCK_LP_CNT_EN
  ,
  output logic [AW:0]   lp_cnt_out
`endif
);

  localparam logic [AW:0]   FULL_CNT  = (AW+1)'(DEPTH);
  localparam logic [AW:0]   AFULL_CNT = (AW+1)'(DEPTH - AFULL_MARGIN);
  localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);

  logic [66:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          push, pop;
  logic [66:0]   head;

  assign empty_out = (count_q == '0);
  assign full_out  = (count_q == FULL_CNT);
  assign afull_out = (count_q >= AFULL_CNT);
  assign cnt_out   = count_q;

  // Words with the valid bit clear are dropped; a pop frees the slot a push into a full queue needs.
  assign pop  = rd_en_in & ~empty_out;
  assign push = wr_en_in & dcd_inst_in[65] & (~full_out | pop);

  assign head         = mem_q[rd_ptr_q];
  assign dcd_inst_out = empty_out ? '0 : head[65:0];
  assign bck_lp_out   = empty_out ? 1'b0 : head[66];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_in) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; stale contents are masked by the empty check on the outputs.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {bck_lp_in, dcd_inst_in};
  end

`ifdef DIQ_BCK_LP_CNT_EN
  logic [AW:0] lp_cnt_q, lp_cnt_d;
  logic        lp_inc, lp_dec;

  assign lp_inc     = push & bck_lp_in;
  assign lp_dec     = pop & head[66];
  assign lp_cnt_out = lp_cnt_q;

  always_comb begin
    lp_cnt_d = lp_cnt_q;
    if (flush_in)
      lp_cnt_d = '0;
    else if (lp_inc && !lp_dec)
      lp_cnt_d = lp_cnt_q + CNT_ONE;
    else if (lp_dec && !lp_inc)
      lp_cnt_d = lp_cnt_q - CNT_ONE;
  end

  always_ff @(posedge clk) begin
    if (rst) lp_cnt_q <= '0;
    else     lp_cnt_q <= lp_cnt_d;
  end
`endif

endmodule

// File: tb/tb_dcd_inst_queue.sv
// Directed bench for dcd_inst_queue: a queue of expected {bck_lp, word} entries is filled on accepted
// pushes and compared against the head on accepted pops; status outputs are checked every cycle.
module tb_dcd_inst_queue;
  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic          clk = 1'b0;
  logic          rst, flush_in, wr_en_in, bck_lp_in, rd_en_in;
  logic [65:0]   dcd_inst_in;
  logic [65:0]   dcd_inst_out;
  logic          bck_lp_out, empty_out, full_out, afull_out;
  logic [AW:0]   cnt_out;
`ifdef DIQ_BCK_LP_CNT_EN
  logic [AW:0]   lp_cnt_out;
`endif

  int            n_pass = 0;
  int            n_total = 0;
  logic [66:0]   sb[$];

  always #5 clk = ~clk;

  dcd_inst_queue #(.DEPTH(DEPTH), .AW(AW), .AFULL_MARGIN(2)) dut (
    .clk(clk), .rst(rst), .flush_in(flush_in), .wr_en_in(wr_en_in),
    .dcd_inst_in(dcd_inst_in), .bck_lp_in(bck_lp_in), .rd_en_in(rd_en_in),
    .dcd_inst_out(dcd_inst_out), .bck_lp_out(bck_lp_out), .empty_out(empty_out),
    .full_out(full_out), .afull_out(afull_out), .cnt_out(cnt_out)
`ifdef DIQ_BCK_LP_CNT_EN
    , .lp_cnt_out(lp_cnt_out)
`endif
  );

  function automatic logic [65:0] mk_word(input logic valid, input logic [15:0] pc);
    return {valid, 1'b0, pc ^ 16'h5a5a, pc, ~pc, pc};
  endfunction

  task automatic chk(input string tag, input logic [66:0] obs, input logic [66:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic chk_status(input string tag);
    logic [66:0] exp_head;
    int          lp;
    exp_head = (sb.size() > 0) ? sb[0] : 67'h0;
    chk({tag, ".cnt"},   67'(cnt_out),   67'(sb.size()));
    chk({tag, ".empty"}, 67'(empty_out), 67'(sb.size() == 0));
    chk({tag, ".full"},  67'(full_out),  67'(sb.size() == DEPTH));
    chk({tag, ".afull"}, 67'(afull_out), 67'(sb.size() >= DEPTH - 2));
    chk({tag, ".head"},  {bck_lp_out, dcd_inst_out}, exp_head);
    lp = 0;
    foreach (sb[k]) if (sb[k][66]) lp++;
`ifdef DIQ_BCK_LP_CNT_EN
    chk({tag, ".lpcnt"}, 67'(lp_cnt_out), 67'(lp));
`endif
    $display("%s: cnt=%0d empty=%0b full=%0b afull=%0b pc=%04h lp_expected=%0d",
             tag, cnt_out, empty_out, full_out, afull_out, dcd_inst_out[15:0], lp);
  endtask

  // One clock of stimulus; the model decides acceptance from its own occupancy.
  task automatic cycle(input string tag, input logic wr, input logic valid, input logic [15:0] pc,
                       input logic bck, input logic rd, input logic fl);
    logic acc_push, acc_pop;
    logic [66:0] ent;
    ent         = {bck, mk_word(valid, pc)};
    wr_en_in    = wr;
    dcd_inst_in = ent[65:0];
    bck_lp_in   = bck;
    rd_en_in    = rd;
    flush_in    = fl;
    acc_pop  = rd && (sb.size() > 0);
    acc_push = wr && valid && ((sb.size() < DEPTH) || acc_pop);
    if (acc_pop && !fl) chk({tag, ".popdata"}, {bck_lp_out, dcd_inst_out}, sb[0]);
    @(posedge clk);
    #1;
    if (fl) sb.delete();
    else begin
      if (acc_pop)  void'(sb.pop_front());
      if (acc_push) sb.push_back(ent);
    end
    wr_en_in = 1'b0; rd_en_in = 1'b0; flush_in = 1'b0;
    chk_status(tag);
  endtask

  initial begin
    rst = 1'b1; flush_in = 1'b0; wr_en_in = 1'b0; rd_en_in = 1'b0;
    bck_lp_in = 1'b0; dcd_inst_in = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk_status("reset");
    cycle("idle", 0, 0, 16'h0, 0, 0, 0);

    for (int i = 0; i < 8; i++)
      cycle($sformatf("fill%0d", i + 1), 1, 1, 16'h0010 + 16'(i), i[0], 0, 0);
    cycle("push_full_drop", 1, 1, 16'h0018, 0, 0, 0);
    cycle("push_pop_full", 1, 1, 16'h0020, 1, 1, 0);
    for (int i = 0; i < 8; i++)
      cycle($sformatf("drain%0d", i + 1), 0, 0, 16'h0, 0, 1, 0);

    cycle("invalid_push", 1, 0, 16'h0030, 0, 0, 0);
    cycle("pop_empty", 0, 0, 16'h0, 0, 1, 0);
    cycle("push_rd_empty", 1, 1, 16'h0031, 0, 1, 0);
    cycle("push_pop_cnt1", 1, 1, 16'h0032, 1, 1, 0);
    cycle("pop_last", 0, 0, 16'h0, 0, 1, 0);

    cycle("lp_push1", 1, 1, 16'h0040, 1, 0, 0);
    cycle("lp_push2", 1, 1, 16'h0041, 0, 0, 0);
    cycle("lp_push3", 1, 1, 16'h0042, 1, 0, 0);
    cycle("lp_pop1", 0, 0, 16'h0, 0, 1, 0);
    cycle("flush_push_pop", 1, 1, 16'h0043, 1, 1, 1);

    cycle("wrap_prime", 1, 1, 16'h0100, 0, 0, 0);
    for (int i = 1; i <= 20; i++)
      cycle($sformatf("wrap%0d", i), 1, 1, 16'h0100 + 16'(i), i[1], 1, 0);
    for (int i = 0; i < 3; i++)
      cycle($sformatf("refill%0d", i), 1, 1, 16'h0200 + 16'(i), 1, 0, 0);

    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb.delete();
    chk_status("midop_reset");
    cycle("post_reset_push", 1, 1, 16'h0300, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
